// File: rtl/rf_wport_arb.sv
// ============================================================================
// Module   : rf_wport_arb
// Brief    : Regfile write-port arbiter; WB has absolute priority, MDU results
//            queue in a 2-entry FIFO and drain into idle write slots.
//            Optional macro RF_ARB_STARVE_EN adds the starvation stall request.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_wport_arb #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_waddr,
  input  logic [31:0] mdu_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy_mask,
  output logic        stall_req
);

  logic [4:0]  r_addr [2];
  logic [31:0] r_data [2];
  logic [1:0]  r_live;
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_wb_cycle;
  logic        w_pop;
  logic        w_enq;
  logic [31:0] w_busy;

  assign w_wb_cycle = wb_we && (wb_waddr != 5'd0);
  assign w_pop      = !w_wb_cycle && (r_count != 2'd0);
  assign mdu_ready  = (r_count != 2'd2);
  // Address-0 results complete the handshake but never occupy a slot.
  assign w_enq      = mdu_valid && mdu_ready && (mdu_waddr != 5'd0);

  // Live flags are cleared on pop, so they alone mark live occupied slots.
  always_comb begin
    w_busy = '0;
    for (int i = 0; i < 2; i++) begin
      if (r_live[i]) w_busy[r_addr[i]] = 1'b1;
    end
  end
  assign busy_mask = {w_busy[31:1], 1'b0};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
      r_live   <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      // Kill only sees entries present at cycle start; a same-cycle enqueue
      // lands in an empty slot and is set live afterwards.
      for (int i = 0; i < 2; i++) begin
        if (w_wb_cycle && r_live[i] && (r_addr[i] == wb_waddr)) r_live[i] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_rd_ptr] <= 1'b0;
        r_rd_ptr         <= ~r_rd_ptr;
      end
      if (w_enq) begin
        r_addr[r_wr_ptr] <= mdu_waddr;
        r_data[r_wr_ptr] <= mdu_wdata;
        r_live[r_wr_ptr] <= 1'b1;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (w_wb_cycle) begin
      rf_we    <= 1'b1;
      rf_waddr <= wb_waddr;
      rf_wdata <= wb_wdata;
    end else if (w_pop && r_live[r_rd_ptr]) begin
      rf_we    <= 1'b1;
      rf_waddr <= r_addr[r_rd_ptr];
      rf_wdata <= r_data[r_rd_ptr];
    end else begin
      rf_we    <= 1'b0;
    end
  end

`ifdef RF_ARB_STARVE_EN
  localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;
  logic [3:0] w_starve_nxt;
  logic       r_stall;

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_pop || (r_count == 2'd0)) w_starve_nxt = '0;
    else if (r_starve_cnt != 4'hF)  w_starve_nxt = r_starve_cnt + 4'd1;
  end

  // Stall is registered alongside the counter so it rises with the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
      r_stall      <= (w_starve_nxt >= c_STARVE_LIMIT);
    end
  end
  assign stall_req = r_stall;
`else
  assign stall_req = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rf_wport_arb.sv
// ============================================================================
// Module   : tb_rf_wport_arb
// Brief    : Directed self-checking bench for rf_wport_arb.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rf_wport_arb;

  logic        clk;
  logic        resetn;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_waddr;
  logic [31:0] mdu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] busy_mask;
  logic        stall_req;

  int n_cmp = 0;
  int n_err = 0;

`ifdef RF_ARB_STARVE_EN
  localparam bit c_STARVE = 1'b1;
`else
  localparam bit c_STARVE = 1'b0;
`endif

  rf_wport_arb #(.STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .mdu_valid (mdu_valid),
    .mdu_ready (mdu_ready),
    .mdu_waddr (mdu_waddr),
    .mdu_wdata (mdu_wdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy_mask (busy_mask),
    .stall_req (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                            input logic mv, input logic [4:0] ma, input logic [31:0] md);
    wb_we = we; wb_waddr = wa; wb_wdata = wd;
    mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_inputs(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
      tick();
    end
    set_inputs(0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'd0) begin n_err++; $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); end
    n_cmp++; if (busy_mask !== 32'd0) begin n_err++; $display("FAIL reset_busy got %h want 0", busy_mask); end
    n_cmp++; if (mdu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %0b want 1", mdu_ready); end
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL reset_stall got %0b want 0", stall_req); end
  endtask

  task automatic test_wb_passthrough();
    set_inputs(1, 5'd5, 32'h1234, 0, 0, 0);
    tick();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h1234}) begin
      n_err++; $display("FAIL wb_pass got we=%0b a=%0d d=%h want we=1 a=5 d=1234", rf_we, rf_waddr, rf_wdata);
    end
    // Address-0 WB plus an address-0 MDU result: no write, nothing queued.
    set_inputs(1, 5'd0, 32'hFFFF, 1, 5'd0, 32'h77);
    tick();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'h1234}) begin
      n_err++; $display("FAIL wb_zero got we=%0b a=%0d d=%h want we=0 a=5 d=1234", rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++; if (busy_mask !== 32'd0 || mdu_ready !== 1'b1) begin
      n_err++; $display("FAIL mdu_zero_discard got busy=%h rdy=%0b want busy=0 rdy=1", busy_mask, mdu_ready);
    end
    set_inputs(0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL mdu_zero_nopop got we=%0b want 0", rf_we); end
  endtask

  task automatic test_queue_drain();
    set_inputs(1, 5'd1, 32'h11, 1, 5'd7, 32'hA);
    tick();
    n_cmp++; if (busy_mask !== 32'h80 || mdu_ready !== 1'b1) begin
      n_err++; $display("FAIL q_one got busy=%h rdy=%0b want busy=80 rdy=1", busy_mask, mdu_ready);
    end
    set_inputs(1, 5'd2, 32'h22, 1, 5'd8, 32'hB);
    tick();
    n_cmp++; if (busy_mask !== 32'h180 || mdu_ready !== 1'b0) begin
      n_err++; $display("FAIL q_full got busy=%h rdy=%0b want busy=180 rdy=0", busy_mask, mdu_ready);
    end
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd2, 32'h22}) begin
      n_err++; $display("FAIL q_wb_wins got we=%0b a=%0d d=%h want we=1 a=2 d=22", rf_we, rf_waddr, rf_wdata);
    end
    // r11 offered while full: refused this cycle (no pop bypass), taken next.
    set_inputs(0, 0, 0, 1, 5'd11, 32'hE);
    tick();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'hA}) begin
      n_err++; $display("FAIL drain_r7 got we=%0b a=%0d d=%h want we=1 a=7 d=a", rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++; if (busy_mask !== 32'h100 || mdu_ready !== 1'b1) begin
      n_err++; $display("FAIL drain_r7_state got busy=%h rdy=%0b want busy=100 rdy=1", busy_mask, mdu_ready);
    end
    tick();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd8, 32'hB}) begin
      n_err++; $display("FAIL drain_r8 got we=%0b a=%0d d=%h want we=1 a=8 d=b", rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++; if (busy_mask !== 32'h800) begin
      n_err++; $display("FAIL enq_pop_same got busy=%h want 800", busy_mask);
    end
    set_inputs(0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd11, 32'hE}) begin
      n_err++; $display("FAIL drain_r11 got we=%0b a=%0d d=%h want we=1 a=11 d=e", rf_we, rf_waddr, rf_wdata);
    end
    n_cmp++; if (busy_mask !== 32'd0) begin n_err++; $display("FAIL drain_empty got busy=%h want 0", busy_mask); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL drain_idle got we=%0b want 0", rf_we); end
  endtask

  task automatic test_kill();
    set_inputs(0, 0, 0, 1, 5'd9, 32'hC);
    tick();
    n_cmp++; if (busy_mask !== 32'h200) begin n_err++; $display("FAIL kill_enq got busy=%h want 200", busy_mask); end
    set_inputs(1, 5'd9, 32'hD, 0, 0, 0);
    tick();
    n_cmp++; if (busy_mask !== 32'd0) begin n_err++; $display("FAIL kill_busy got busy=%h want 0", busy_mask); end
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'hD}) begin
      n_err++; $display("FAIL kill_wb got we=%0b a=%0d d=%h want we=1 a=9 d=d", rf_we, rf_waddr, rf_wdata);
    end
    set_inputs(0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (rf_we !== 1'b0 || rf_wdata !== 32'hD) begin
      n_err++; $display("FAIL kill_dead_pop got we=%0b d=%h want we=0 d=d", rf_we, rf_wdata);
    end
    // Dead pop must have emptied the buffer: two fresh entries fill it.
    set_inputs(1, 5'd3, 32'h3, 1, 5'd12, 32'h1);
    tick();
    set_inputs(1, 5'd3, 32'h3, 1, 5'd13, 32'h2);
    tick();
    n_cmp++; if (busy_mask !== 32'h3000 || mdu_ready !== 1'b0) begin
      n_err++; $display("FAIL kill_refill got busy=%h rdy=%0b want busy=3000 rdy=0", busy_mask, mdu_ready);
    end
    set_inputs(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    n_cmp++; if (busy_mask !== 32'd0 || rf_waddr !== 5'd13) begin
      n_err++; $display("FAIL kill_refill_drain got busy=%h a=%0d want busy=0 a=13", busy_mask, rf_waddr);
    end
  endtask

  task automatic test_starvation();
    logic exp;
    // Enqueue r10 while WB is busy; counting begins the following cycle (cycle 0).
    set_inputs(1, 5'd3, 32'h33, 1, 5'd10, 32'h10);
    tick();
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL starve_enq got %0b want 0", stall_req); end
    set_inputs(1, 5'd3, 32'h33, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      exp = c_STARVE && ((k + 1) >= 4);
      n_cmp++; if (stall_req !== exp) begin
        n_err++; $display("FAIL starve_cyc%0d got %0b want %0b", k + 1, stall_req, exp);
      end
    end
    set_inputs(0, 0, 0, 0, 0, 0);
    tick();
    n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL starve_clear got %0b want 0", stall_req); end
    n_cmp++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'h10}) begin
      n_err++; $display("FAIL starve_pop got we=%0b a=%0d d=%h want we=1 a=10 d=10", rf_we, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_reset_midop();
    set_inputs(1, 5'd4, 32'h44, 1, 5'd14, 32'h5);
    tick();
    resetn = 1'b0;
    #1;
    n_cmp++; if (busy_mask !== 32'd0 || rf_we !== 1'b0 || rf_waddr !== 5'd0) begin
      n_err++; $display("FAIL midop_reset got busy=%h we=%0b a=%0d want 0 0 0", busy_mask, rf_we, rf_waddr);
    end
    set_inputs(0, 0, 0, 0, 0, 0);
    tick();
    resetn = 1'b1;
    tick();
    n_cmp++; if (rf_we !== 1'b0 || mdu_ready !== 1'b1) begin
      n_err++; $display("FAIL midop_lost got we=%0b rdy=%0b want we=0 rdy=1", rf_we, mdu_ready);
    end
  endtask

  initial begin
    resetn = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0);
    test_reset();
    test_wb_passthrough();
    test_queue_drain();
    test_kill();
    test_starvation();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
